// File: rtl/vend_pkg.sv
// Shared definitions for the vending session controller: coin codes, coin values,
// FSM state encoding and the change-coin unit.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_25   = 2'b11;

  localparam int CHANGE_UNIT = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_5:  coin_value = 5'd5;
      COIN_10: coin_value = 5'd10;
      COIN_25: coin_value = 5'd25;
      default: coin_value = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// searching upward with wrap. The pointer register is owned by the caller.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0]   pos;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    pos     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) pos = pos - (IDX_W + 1)'(N);
      idx = pos[IDX_W-1:0];
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/vend_session_ctrl.sv
// Vending session controller: round-robin coin intake onto a shared credit register,
// dispense handshake, then change or refund paid out as 5-unit pulses.
module vend_session_ctrl
  import vend_pkg::*;
#(
  parameter int N_PORTS  = 2,
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_PORTS-1:0]         coin_valid,
  input  logic [2*N_PORTS-1:0]       coin_code,
  output logic [N_PORTS-1:0]         coin_ready,
  input  logic                       cancel,
  output logic                       disp_req,
  input  logic                       disp_ack,
  output logic                       chg_req,
  input  logic                       chg_ack,
  output logic [CREDIT_W-1:0]        credit,
  output logic                       busy,
  output logic [$clog2(N_PORTS)-1:0] vend_port
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] UNIT_C  = CREDIT_W'(CHANGE_UNIT);

  state_t              state;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    gnt_idx;
  logic [IDX_W-1:0]    ptr_next;
  logic [N_PORTS-1:0]  req;
  logic [N_PORTS-1:0]  gnt;
  logic [1:0]          sel_code;
  logic [CREDIT_W-1:0] coin_amt;
  logic [CREDIT_W-1:0] credit_sum;
  logic                refund_hit;
  logic                xfer;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_PORTS; i++)
      req[i] = coin_valid[i] && (coin_code[2*i +: 2] != COIN_NONE);
  end

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A refund request with credit present pre-empts coin intake for that cycle.
  assign refund_hit = (state == IDLE) && cancel && (credit != '0);
  assign coin_ready = ((state == IDLE) && !refund_hit) ? gnt : '0;
  assign xfer       = |coin_ready;

  always_comb begin
    sel_code = COIN_NONE;
    for (int i = 0; i < N_PORTS; i++)
      if (gnt[i]) sel_code = coin_code[2*i +: 2];
  end

  assign coin_amt   = CREDIT_W'(coin_value(sel_code));
  assign credit_sum = credit + coin_amt;
  assign ptr_next   = (gnt_idx == IDX_W'(N_PORTS - 1)) ? '0 : gnt_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      credit    <= '0;
      rr_ptr    <= '0;
      vend_port <= '0;
      disp_req  <= 1'b0;
      chg_req   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (refund_hit) begin
            state   <= CHANGE;
            chg_req <= 1'b1;
            busy    <= 1'b1;
          end else if (xfer) begin
            credit <= credit_sum;
            rr_ptr <= ptr_next;
            if (credit_sum >= PRICE_C) begin
              state     <= VEND;
              vend_port <= gnt_idx;
              disp_req  <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        VEND: begin
          if (disp_ack) begin
            credit   <= credit - PRICE_C;
            disp_req <= 1'b0;
            if (credit != PRICE_C) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          // Leave on the edge that pays out the last coin, so chg_req never overshoots.
          if (chg_ack) begin
            credit <= credit - UNIT_C;
            if (credit == UNIT_C) begin
              state   <= IDLE;
              chg_req <= 1'b0;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          disp_req <= 1'b0;
          chg_req  <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_session_ctrl.sv
// Directed bench for vend_session_ctrl (N_PORTS=2, PRICE=15, CREDIT_W=6).
module tb_vend_session_ctrl;

  logic       clk;
  logic       rst;
  logic [1:0] coin_valid;
  logic [3:0] coin_code;
  logic [1:0] coin_ready;
  logic       cancel;
  logic       disp_req;
  logic       disp_ack;
  logic       chg_req;
  logic       chg_ack;
  logic [5:0] credit;
  logic       busy;
  logic [0:0] vend_port;

  int errors = 0;
  int checks = 0;

  vend_session_ctrl #(.N_PORTS(2), .PRICE(15), .CREDIT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .coin_valid (coin_valid),
    .coin_code  (coin_code),
    .coin_ready (coin_ready),
    .cancel     (cancel),
    .disp_req   (disp_req),
    .disp_ack   (disp_ack),
    .chg_req    (chg_req),
    .chg_ack    (chg_ack),
    .credit     (credit),
    .busy       (busy),
    .vend_port  (vend_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; coin_valid = 2'b00; coin_code = 4'b0000;
    cancel = 1'b0; disp_ack = 1'b0; chg_ack = 1'b0;
    #2;
    chk("rst_credit", credit, 0);
    chk("rst_disp", disp_req, 0);
    chk("rst_chg", chg_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", coin_ready, 0);
    chk("rst_port", vend_port, 0);
    tick();
    rst = 1'b1;

    // Port0: 10 then 5 reaches the price exactly
    coin_valid = 2'b01; coin_code = 4'b0010; #1;
    chk("t1_ready10", coin_ready, 2'b01);
    tick();
    chk("t1_credit10", credit, 10);
    chk("t1_busy_idle", busy, 0);
    coin_code = 4'b0001; #1;
    chk("t1_ready5", coin_ready, 2'b01);
    tick();
    coin_valid = 2'b00;
    chk("t1_credit15", credit, 15);
    chk("t1_disp_req", disp_req, 1);
    chk("t1_busy", busy, 1);
    chk("t1_vport", vend_port, 0);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("t1_credit0", credit, 0);
    chk("t1_disp_drop", disp_req, 0);
    chk("t1_no_chg", chg_req, 0);
    chk("t1_idle", busy, 0);

    // Port1: 25 -> vend, then 10 change as two pulses
    coin_valid = 2'b10; coin_code = 4'b1100; #1;
    chk("t2_ready", coin_ready, 2'b10);
    tick();
    coin_valid = 2'b00;
    chk("t2_credit25", credit, 25);
    chk("t2_disp_req", disp_req, 1);
    chk("t2_vport", vend_port, 1);
    tick();
    chk("t2_disp_hold", disp_req, 1);
    chk("t2_credit_hold", credit, 25);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("t2_credit10", credit, 10);
    chk("t2_disp_drop", disp_req, 0);
    chk("t2_chg_req", chg_req, 1);
    chk("t2_busy", busy, 1);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    chk("t2_credit5", credit, 5);
    chk("t2_chg_hold", chg_req, 1);
    tick();
    chk("t2_no_ack_hold", credit, 5);
    chg_ack = 1'b1; tick(); chg_ack = 1'b0;
    chk("t2_credit0", credit, 0);
    chk("t2_chg_drop", chg_req, 0);
    chk("t2_idle", busy, 0);

    // Both ports request 5 continuously: grants alternate 0,1,0; stall during vend
    coin_valid = 2'b11; coin_code = 4'b0101; #1;
    chk("t3_gnt0", coin_ready, 2'b01);
    tick();
    chk("t3_credit5", credit, 5);
    chk("t3_gnt1", coin_ready, 2'b10);
    tick();
    chk("t3_credit10", credit, 10);
    chk("t3_gnt0b", coin_ready, 2'b01);
    tick();
    chk("t3_credit15", credit, 15);
    chk("t3_vport", vend_port, 0);
    chk("t3_stall", coin_ready, 2'b00);
    disp_ack = 1'b1; tick(); disp_ack = 1'b0;
    chk("t3_credit0", credit, 0);
    chk("t3_gnt1b", coin_ready, 2'b10);
    coin_valid = 2'b00; #1;

    // Cancel beats a simultaneous coin; that coin is accepted after the refund
    coin_valid = 2'b01; coin_code = 4'b0010; tick();
    chk("t4_credit10", credit, 10);
    coin_code = 4'b0001; cancel = 1'b1; #1;
    chk("t4_cancel_blocks", coin_ready, 2'b00);
    tick(); cancel = 1'b0;
    chk("t4_credit_kept", credit, 10);
    chk("t4_chg_req", chg_req, 1);
    chk("t4_stall", coin_ready, 2'b00);
    chg_ack = 1'b1; tick();
    chk("t4_credit5", credit, 5);
    tick(); chg_ack = 1'b0;
    chk("t4_credit0", credit, 0);
    chk("t4_idle", busy, 0);
    chk("t4_chg_drop", chg_req, 0);
    chk("t4_coin_ready", coin_ready, 2'b01);
    tick();
    coin_valid = 2'b00;
    chk("t4_coin_taken", credit, 5);

    // Code 00 never granted; stray acks in IDLE ignored
    coin_valid = 2'b01; coin_code = 4'b0000; #1;
    chk("t6_code00", coin_ready, 2'b00);
    disp_ack = 1'b1; chg_ack = 1'b1; tick();
    disp_ack = 1'b0; chg_ack = 1'b0; coin_valid = 2'b00;
    chk("t6_credit", credit, 5);
    chk("t6_busy", busy, 0);
    chk("t6_disp", disp_req, 0);
    chk("t6_chg", chg_req, 0);

    // Reach credit 20 in VEND, then reset mid-vend
    coin_valid = 2'b10; coin_code = 4'b0100; #1;
    chk("t5_ready_p1", coin_ready, 2'b10);
    tick();
    chk("t5_credit10", credit, 10);
    coin_valid = 2'b01; coin_code = 4'b0010; tick();
    coin_valid = 2'b00;
    chk("t5_credit20", credit, 20);
    chk("t5_vend", disp_req, 1);
    #2 rst = 1'b0; #1;
    chk("t5_rst_credit", credit, 0);
    chk("t5_rst_disp", disp_req, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_chg", chg_req, 0);
    tick();
    rst = 1'b1;
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("t5_cancel_zero", busy, 0);
    chk("t5_cancel_nochg", chg_req, 0);
    coin_valid = 2'b10; coin_code = 4'b1000; #1;
    chk("t5_resume_ready", coin_ready, 2'b10);
    tick();
    coin_valid = 2'b00;
    chk("t5_resume_credit", credit, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
